l1_icache_mt: RTL and testbench

Multi-threaded L1 instruction cache for the interleaved-multithreading core; the parametrised successor to the one-line-per-thread fetch buffer.
- Holds LINES_PER_THREAD fully-associative lines per hardware thread.
- Serves the fetch stage with a combinational same-cycle hit/instruction lookup.
- Runs one refill state machine per thread, arbitrated onto a single valid/ready request channel to L2.
- Sits between the fetch stage (PC, branch redirect) and the L2 cache.

---
 rtl/l1_icache_mt_if.sv | 45 ++++
 rtl/l1_icache_mt.sv | 216 +++++++++++++++++++++
 tb/tb_l1_icache_mt.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/l1_icache_mt_if.sv
// Fetch, branch, L2 request/response and status bundle for the multithreaded L1 I-cache.
// Latency: none, pure wiring.
// Backpressure: L2 requests use valid/ready; fetch, branch and L2 responses are unthrottled.
interface l1_icache_mt_if #(
    parameter int NUM_THREADS    = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
);
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic                        fetch_valid;
    logic [TID_W-1:0]            fetch_tid;
    logic [ADDR_W-1:0]           fetch_addr;
    logic                        br_valid;
    logic [TID_W-1:0]            br_tid;
    logic [ADDR_W-1:0]           br_target;
    logic                        l2_req_valid;
    logic                        l2_req_ready;
    logic [TID_W-1:0]            l2_req_tid;
    logic [ADDR_W-1:0]           l2_req_addr;
    logic                        l2_req_spec;
    logic                        l2_rsp_valid;
    logic [TID_W-1:0]            l2_rsp_tid;
    logic [ADDR_W-1:0]           l2_rsp_addr;
    logic [32*WORDS_PER_LINE-1:0] l2_rsp_line;
    logic                        hit;
    logic [31:0]                 instr;
    logic [NUM_THREADS-1:0]      miss_pending;

    // Environment side: fetch stage plus L2.
    modport master (
        output fetch_valid, fetch_tid, fetch_addr, br_valid, br_tid, br_target,
        output l2_req_ready, l2_rsp_valid, l2_rsp_tid, l2_rsp_addr, l2_rsp_line,
        input  l2_req_valid, l2_req_tid, l2_req_addr, l2_req_spec,
        input  hit, instr, miss_pending
    );

    // Cache side.
    modport slave (
        input  fetch_valid, fetch_tid, fetch_addr, br_valid, br_tid, br_target,
        input  l2_req_ready, l2_rsp_valid, l2_rsp_tid, l2_rsp_addr, l2_rsp_line,
        output l2_req_valid, l2_req_tid, l2_req_addr, l2_req_spec,
        output hit, instr, miss_pending
    );
endinterface

// File: rtl/l1_icache_mt.sv
// Multithreaded fully-associative L1 I-cache, one refill FSM per thread, RR arbitration to L2.
// Latency: fetch hit/instr combinational; miss request appears the cycle after the miss.
// Backpressure: L2 request held stable (tid locked) while valid && !ready; fetch never stalls.
// Optional: define L1_NEXT_LINE_PREFETCH_EN to build next-line prefetch on last-word hits.
module l1_icache_mt #(
    parameter int          NUM_THREADS      = 4,
    parameter int          LINES_PER_THREAD = 2,
    parameter int          WORDS_PER_LINE   = 4,
    parameter int          ADDR_W           = 32,
    parameter logic [31:0] BUBBLE           = 32'h0000_0013
) (
    input  logic          clock,
    input  logic          reset,
    l1_icache_mt_if.slave bus
);
    localparam int TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int OFF_W  = $clog2(WORDS_PER_LINE) + 2;
    localparam int WIDX_W = OFF_W - 2;
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int VIC_W  = (LINES_PER_THREAD > 1) ? $clog2(LINES_PER_THREAD) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} st_e;

    st_e                            st_q       [NUM_THREADS];
    st_e                            st_d       [NUM_THREADS];
    logic [LINE_W-1:0]              line_q     [NUM_THREADS];
    logic [LINE_W-1:0]              line_d     [NUM_THREADS];
    logic                           spec_q     [NUM_THREADS];
    logic                           spec_d     [NUM_THREADS];
    logic                           rdr_vld_q  [NUM_THREADS];
    logic                           rdr_vld_d  [NUM_THREADS];
    logic [LINE_W-1:0]              rdr_line_q [NUM_THREADS];
    logic [LINE_W-1:0]              rdr_line_d [NUM_THREADS];
    logic                           fill_we    [NUM_THREADS];
    logic [VIC_W-1:0]               vic_q      [NUM_THREADS];
    logic [LINES_PER_THREAD-1:0]    vld_q      [NUM_THREADS];
    logic [LINE_W-1:0]              tag_q      [NUM_THREADS][LINES_PER_THREAD];
    logic [WORDS_PER_LINE-1:0][31:0] data_q    [NUM_THREADS][LINES_PER_THREAD];

    logic [TID_W-1:0] rr_q, lock_tid_q, gnt_tid;
    logic             lock_vld_q, gnt_vld, rsp_acc, hit_c;
    logic [31:0]      instr_c;

    wire [LINE_W-1:0]               fline     = bus.fetch_addr[ADDR_W-1:OFF_W];
    wire [WIDX_W-1:0]               fword     = bus.fetch_addr[OFF_W-1:2];
    wire [LINE_W-1:0]               bline     = bus.br_target[ADDR_W-1:OFF_W];
    wire [LINE_W-1:0]               rline     = bus.l2_rsp_addr[ADDR_W-1:OFF_W];
    wire [WORDS_PER_LINE-1:0][31:0] rsp_words = bus.l2_rsp_line;
    wire                            unused_bits = ^{bus.fetch_addr[1:0], bus.br_target[OFF_W-1:0],
                                                    bus.l2_rsp_addr[OFF_W-1:0]};

    // True when thread t already holds line ln.
    function automatic logic line_hit(input int t, input logic [LINE_W-1:0] ln);
        line_hit = 1'b0;
        for (int l = 0; l < LINES_PER_THREAD; l++)
            if (vld_q[t][l] && tag_q[t][l] == ln) line_hit = 1'b1;
    endfunction

    // A response is consumed only by its thread waiting on exactly that line.
    assign rsp_acc = bus.l2_rsp_valid && st_q[bus.l2_rsp_tid] == WAIT &&
                     line_q[bus.l2_rsp_tid] == rline;

    // Same-cycle lookup over the fetching thread's lines, plus bypass from an accepted fill.
    always_comb begin
        hit_c   = 1'b0;
        instr_c = BUBBLE;
        if (bus.fetch_valid) begin
            for (int l = 0; l < LINES_PER_THREAD; l++) begin
                if (vld_q[bus.fetch_tid][l] && tag_q[bus.fetch_tid][l] == fline) begin
                    hit_c   = 1'b1;
                    instr_c = data_q[bus.fetch_tid][l][fword];
                end
            end
            if (rsp_acc && bus.l2_rsp_tid == bus.fetch_tid && rline == fline) begin
                hit_c   = 1'b1;
                instr_c = rsp_words[fword];
            end
        end
    end

    // Round-robin pick among REQ threads; a stalled grant stays locked so fields hold.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_tid = '0;
        if (lock_vld_q && st_q[lock_tid_q] == REQ) begin
            gnt_vld = 1'b1;
            gnt_tid = lock_tid_q;
        end else begin
            for (int i = NUM_THREADS - 1; i >= 0; i--) begin
                if (st_q[(int'(rr_q) + i) % NUM_THREADS] == REQ) begin
                    gnt_vld = 1'b1;
                    gnt_tid = TID_W'((int'(rr_q) + i) % NUM_THREADS);
                end
            end
        end
    end

    // Per-thread refill FSM next state; branch beats fetch, a redirect during WAIT is held.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            st_d[t]       = st_q[t];
            line_d[t]     = line_q[t];
            spec_d[t]     = spec_q[t];
            rdr_vld_d[t]  = rdr_vld_q[t];
            rdr_line_d[t] = rdr_line_q[t];
            fill_we[t]    = 1'b0;
            case (st_q[t])
                IDLE: begin
                    if (bus.br_valid && bus.br_tid == TID_W'(t)) begin
                        if (!line_hit(t, bline)) begin
                            st_d[t]   = REQ;
                            line_d[t] = bline;
                            spec_d[t] = 1'b1;
                        end
                    end else if (bus.fetch_valid && bus.fetch_tid == TID_W'(t) && !hit_c) begin
                        st_d[t]   = REQ;
                        line_d[t] = fline;
                        spec_d[t] = 1'b0;
                    end
`ifdef L1_NEXT_LINE_PREFETCH_EN
                    else if (bus.fetch_valid && bus.fetch_tid == TID_W'(t) && hit_c &&
                             fword == '1 && !line_hit(t, fline + LINE_W'(1))) begin
                        st_d[t]   = REQ;
                        line_d[t] = fline + LINE_W'(1);
                        spec_d[t] = 1'b1;
                    end
`endif
                end
                REQ: begin
                    if (gnt_vld && gnt_tid == TID_W'(t) && bus.l2_req_ready) begin
                        // Request already left with the old line; a concurrent branch waits.
                        st_d[t] = WAIT;
                        if (bus.br_valid && bus.br_tid == TID_W'(t)) begin
                            rdr_vld_d[t]  = 1'b1;
                            rdr_line_d[t] = bline;
                        end
                    end else if (bus.br_valid && bus.br_tid == TID_W'(t)) begin
                        line_d[t] = bline;
                        spec_d[t] = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.br_valid && bus.br_tid == TID_W'(t)) begin
                        rdr_vld_d[t]  = 1'b1;
                        rdr_line_d[t] = bline;
                    end
                    if (rsp_acc && bus.l2_rsp_tid == TID_W'(t)) begin
                        fill_we[t]   = !line_hit(t, rline);
                        st_d[t]      = IDLE;
                        rdr_vld_d[t] = 1'b0;
                        if ((bus.br_valid && bus.br_tid == TID_W'(t)) || rdr_vld_q[t]) begin
                            if (!line_hit(t, rdr_line_d[t]) && rdr_line_d[t] != rline) begin
                                st_d[t]   = REQ;
                                line_d[t] = rdr_line_d[t];
                                spec_d[t] = 1'b1;
                            end
                        end
                    end
                end
                default: st_d[t] = IDLE;
            endcase
        end
    end

    // State, line storage, victim and arbiter pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                st_q[t]       <= IDLE;
                line_q[t]     <= '0;
                spec_q[t]     <= 1'b0;
                rdr_vld_q[t]  <= 1'b0;
                rdr_line_q[t] <= '0;
                vic_q[t]      <= '0;
                vld_q[t]      <= '0;
                for (int l = 0; l < LINES_PER_THREAD; l++) begin
                    tag_q[t][l]  <= '0;
                    data_q[t][l] <= '0;
                end
            end
            rr_q       <= '0;
            lock_vld_q <= 1'b0;
            lock_tid_q <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                st_q[t]       <= st_d[t];
                line_q[t]     <= line_d[t];
                spec_q[t]     <= spec_d[t];
                rdr_vld_q[t]  <= rdr_vld_d[t];
                rdr_line_q[t] <= rdr_line_d[t];
                if (fill_we[t]) begin
                    vld_q[t][vic_q[t]]  <= 1'b1;
                    tag_q[t][vic_q[t]]  <= rline;
                    data_q[t][vic_q[t]] <= bus.l2_rsp_line;
                    vic_q[t] <= (vic_q[t] == VIC_W'(LINES_PER_THREAD - 1)) ? '0 : vic_q[t] + VIC_W'(1);
                end
            end
            if (gnt_vld && bus.l2_req_ready)
                rr_q <= (gnt_tid == TID_W'(NUM_THREADS - 1)) ? '0 : gnt_tid + TID_W'(1);
            lock_vld_q <= gnt_vld && !bus.l2_req_ready;
            lock_tid_q <= gnt_tid;
        end
    end

    assign bus.hit          = hit_c;
    assign bus.instr        = instr_c;
    assign bus.l2_req_valid = gnt_vld;
    assign bus.l2_req_tid   = gnt_tid;
    assign bus.l2_req_addr  = {line_q[gnt_tid], {OFF_W{1'b0}}};
    assign bus.l2_req_spec  = gnt_vld && spec_q[gnt_tid];

    // Thread status for the core scheduler.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) bus.miss_pending[t] = (st_q[t] != IDLE);
    end
endmodule

// File: tb/tb_l1_icache_mt.sv
module tb_l1_icache_mt;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    l1_icache_mt_if #(.NUM_THREADS(4), .WORDS_PER_LINE(4), .ADDR_W(32)) bus();

    l1_icache_mt dut (.clock(clock), .reset(reset), .bus(bus.slave));

    typedef struct packed { logic h; logic [31:0] ins; } look_t;
    typedef struct packed { logic [1:0] tid; logic [31:0] addr; logic spec; } req_t;

    look_t look_q[$];
    req_t  req_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Line content is tagged by address: word at byte address a reads 0x5A000000 | a.
    function automatic logic [127:0] mkline(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mkline[32*i +: 32] = 32'h5A00_0000 | (base + 32'(4 * i));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        bus.fetch_valid  = 1'b0;
        bus.l2_rsp_valid = 1'b0;
        bus.br_valid     = 1'b0;
    endtask

    task automatic set_fetch(input logic [1:0] tid, input logic [31:0] a, input logic h, input logic [31:0] ins);
        bus.fetch_valid = 1'b1;
        bus.fetch_tid   = tid;
        bus.fetch_addr  = a;
        look_q.push_back('{h: h, ins: ins});
    endtask

    task automatic set_rsp(input logic [1:0] tid, input logic [31:0] base);
        bus.l2_rsp_valid = 1'b1;
        bus.l2_rsp_tid   = tid;
        bus.l2_rsp_addr  = base;
        bus.l2_rsp_line  = mkline(base);
    endtask

    task automatic set_br(input logic [1:0] tid, input logic [31:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_tid    = tid;
        bus.br_target = tgt;
    endtask

    // Expect one request, wait (bounded) for it, and accept it.
    task automatic serve(input logic [1:0] tid, input logic [31:0] a, input logic spec);
        int n = 0;
        while (!bus.l2_req_valid && n < 10) begin tick(); n++; end
        if (!bus.l2_req_valid) begin
            checks++; errors++;
            $display("FAIL req_timeout: no request, expected tid %0d addr %h", tid, a);
        end else begin
            req_q.push_back('{tid: tid, addr: a, spec: spec});
            bus.l2_req_ready = 1'b1;
            tick();
            bus.l2_req_ready = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a lookup or a request handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.fetch_valid) begin
                if (look_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lookup_unexpected: hit %b instr %h with no expectation", bus.hit, bus.instr);
                end else begin
                    look_t e;
                    e = look_q.pop_front();
                    chk($sformatf("hit@%h", bus.fetch_addr), {31'b0, bus.hit}, {31'b0, e.h});
                    chk($sformatf("instr@%h", bus.fetch_addr), bus.instr, e.ins);
                end
            end
            if (bus.l2_req_valid && bus.l2_req_ready) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: tid %0d addr %h spec %b", bus.l2_req_tid, bus.l2_req_addr, bus.l2_req_spec);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_tid", {30'b0, bus.l2_req_tid}, {30'b0, r.tid});
                    chk("req_addr", bus.l2_req_addr, r.addr);
                    chk("req_spec", {31'b0, bus.l2_req_spec}, {31'b0, r.spec});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_valid = 0; bus.fetch_tid = 0; bus.fetch_addr = 0;
        bus.br_valid = 0; bus.br_tid = 0; bus.br_target = 0;
        bus.l2_req_ready = 0; bus.l2_rsp_valid = 0; bus.l2_rsp_tid = 0;
        bus.l2_rsp_addr = 0; bus.l2_rsp_line = 0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_req_valid", {31'b0, bus.l2_req_valid}, 32'd0);
        chk("rst_req_spec", {31'b0, bus.l2_req_spec}, 32'd0);
        chk("rst_miss_pending", {28'b0, bus.miss_pending}, 32'd0);
        chk("rst_hit", {31'b0, bus.hit}, 32'd0);
        chk("rst_instr", bus.instr, NOP);

        // Basic miss, request, fill, hit
        set_fetch(0, 32'h100, 1'b0, NOP); tick();
        chk("t1_req_valid", {31'b0, bus.l2_req_valid}, 32'd1);
        chk("t1_req_tid", {30'b0, bus.l2_req_tid}, 32'd0);
        chk("t1_req_addr", bus.l2_req_addr, 32'h100);
        chk("t1_req_spec", {31'b0, bus.l2_req_spec}, 32'd0);
        serve(0, 32'h100, 1'b0);
        chk("t1_pending", {28'b0, bus.miss_pending}, 32'h1);
        set_rsp(0, 32'h100); tick();
        set_fetch(0, 32'h108, 1'b1, 32'h5A00_0108); tick();
        chk("t1_pending_clr", {28'b0, bus.miss_pending}, 32'h0);

        // Bypass from the response in the same cycle
        set_fetch(1, 32'h200, 1'b0, NOP); tick();
        serve(1, 32'h200, 1'b0);
        set_fetch(1, 32'h204, 1'b1, 32'h5A00_0204); set_rsp(1, 32'h200); tick();
        set_fetch(1, 32'h208, 1'b1, 32'h5A00_0208); tick();

        // Eviction: third fill of thread 2 replaces the oldest line
        foreach (look_q[i]) ;
        for (int i = 0; i < 3; i++) begin
            set_fetch(2, 32'(16 * i), 1'b0, NOP); tick();
            serve(2, 32'(16 * i), 1'b0);
            set_rsp(2, 32'(16 * i)); tick();
        end
        set_fetch(2, 32'h010, 1'b1, 32'h5A00_0010); tick();
        set_fetch(2, 32'h020, 1'b1, 32'h5A00_0020); tick();
        set_fetch(2, 32'h000, 1'b0, NOP); tick();
        serve(2, 32'h000, 1'b0);
        set_rsp(2, 32'h000); tick();

        // Reset mid-refill: the later response must be dropped
        set_fetch(1, 32'h700, 1'b0, NOP); tick();
        serve(1, 32'h700, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        set_rsp(1, 32'h700); tick();
        chk("rst2_pending", {28'b0, bus.miss_pending}, 32'h0);

        // Arbitration with a stalled channel, then consecutive grants
        set_fetch(0, 32'h300, 1'b0, NOP); tick();
        set_fetch(1, 32'h700, 1'b0, NOP); tick();
        set_fetch(3, 32'h380, 1'b0, NOP); tick();
        for (int i = 0; i < 3; i++) begin
            chk("arb_hold_valid", {31'b0, bus.l2_req_valid}, 32'd1);
            chk("arb_hold_tid", {30'b0, bus.l2_req_tid}, 32'd0);
            chk("arb_hold_addr", bus.l2_req_addr, 32'h300);
            tick();
        end
        req_q.push_back('{tid: 2'd0, addr: 32'h300, spec: 1'b0});
        req_q.push_back('{tid: 2'd1, addr: 32'h700, spec: 1'b0});
        req_q.push_back('{tid: 2'd3, addr: 32'h380, spec: 1'b0});
        bus.l2_req_ready = 1'b1;
        tick(); tick(); tick();
        bus.l2_req_ready = 1'b0;
        chk("arb_pending", {28'b0, bus.miss_pending}, 32'hB);
        chk("arb_idle_valid", {31'b0, bus.l2_req_valid}, 32'd0);
        set_rsp(0, 32'h300); tick();
        set_rsp(1, 32'h700); tick();
        set_rsp(3, 32'h380); tick();
        chk("arb_pending_clr", {28'b0, bus.miss_pending}, 32'h0);

        // Branch while waiting, plus a mismatched response
        set_fetch(0, 32'h100, 1'b0, NOP); tick();
        serve(0, 32'h100, 1'b0);
        set_br(0, 32'h400); tick();
        set_rsp(0, 32'h500); tick();
        set_fetch(0, 32'h500, 1'b0, NOP); tick();
        chk("br_wait_pending", {28'b0, bus.miss_pending}, 32'h1);
        set_rsp(0, 32'h100); tick();
        serve(0, 32'h400, 1'b1);
        set_rsp(0, 32'h400); tick();
        set_fetch(0, 32'h404, 1'b1, 32'h5A00_0404); tick();

        // Last-word hit: next-line prefetch only when built in
        set_fetch(0, 32'h10C, 1'b1, 32'h5A00_010C); tick();
`ifdef L1_NEXT_LINE_PREFETCH_EN
        serve(0, 32'h110, 1'b1);
        set_rsp(0, 32'h110); tick();
`else
        tick(); tick();
        chk("nopf_req_valid", {31'b0, bus.l2_req_valid}, 32'd0);
`endif
        chk("pf_pending_clr", {28'b0, bus.miss_pending}, 32'h0);

        // Branch in IDLE: hitting target does nothing, missing target requests speculatively
        set_br(0, 32'h400); tick();
        chk("br_hit_pending", {28'b0, bus.miss_pending}, 32'h0);
        set_br(0, 32'h600); tick();
        serve(0, 32'h600, 1'b1);
        set_rsp(0, 32'h600); tick();
        set_fetch(0, 32'h608, 1'b1, 32'h5A00_0608); tick();

        tick(); tick();
        chk("look_q_drained", look_q.size(), 32'd0);
        chk("req_q_drained", req_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
